nmea_sentence_gen: RTL and testbench

Encoder counterpart of the NMEA field extractor. It takes one set of binary fix fields (same scaling the extractor produces) and serialises a complete $xxRMC sentence, with checksum and CR/LF, as a byte stream. It sits between the telemetry/fix source and the UART transmit path. Feeding its output back through the extractor reproduces the input fields.

---
 rtl/nmea_pkg.sv | 49 ++++
 rtl/nmea_sentence_gen_bin2bcd.sv | 45 ++++
 rtl/nmea_sentence_gen.sv | 209 ++++++++++++++++++++
 tb/tb_nmea_sentence_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// rtl/nmea_pkg.sv - shared constants, state type and helpers for the RMC sentence generator
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_N      = 8'h4E;
    localparam logic [7:0] ASCII_S      = 8'h53;
    localparam logic [7:0] ASCII_E      = 8'h45;
    localparam logic [7:0] ASCII_W      = 8'h57;
    localparam logic [7:0] ASCII_R      = 8'h52;
    localparam logic [7:0] ASCII_M      = 8'h4D;
    localparam logic [7:0] ASCII_C      = 8'h43;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

    localparam int BCD_DIGITS = 10;
    localparam int UTC_DIGITS = 9;
    localparam int LAT_DIGITS = 8;
    localparam int LON_DIGITS = 9;
    localparam int SPD_DIGITS = 5;

    localparam logic [31:0] UTC_MAX = 32'd999999999;
    localparam logic [31:0] LAT_MAX = 32'd99999999;
    localparam logic [31:0] LON_MAX = 32'd999999999;
    localparam logic [31:0] SPD_MAX = 32'd99999;

    localparam int SENTENCE_LEN = 60;
    localparam logic [5:0] LAST_IDX     = 6'(SENTENCE_LEN - 1);
    // Checksum covers the bytes between '$' (index 0) and '*' (index 55)
    localparam logic [5:0] CS_FIRST_IDX = 6'd1;
    localparam logic [5:0] CS_LAST_IDX  = 6'd54;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/nmea_sentence_gen_bin2bcd.sv
// rtl/nmea_sentence_gen_bin2bcd.sv - sequential double-dabble, 32-bit binary to 10 BCD digits
module nmea_bin2bcd
    import nmea_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [31:0]             bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    logic [31:0]             shreg;
    logic [5:0]              cnt;
    logic [4*BCD_DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (load) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= 6'd32;
            done  <= 1'b0;
        end else if (cnt != 6'd0) begin
            bcd   <= {adj[4*BCD_DIGITS-2:0], shreg[31]};
            shreg <= {shreg[30:0], 1'b0};
            cnt   <= cnt - 6'd1;
            done  <= (cnt == 6'd1);
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/nmea_sentence_gen.sv
// rtl/nmea_sentence_gen.sv - serialises one binary fix as a checksummed $xxRMC byte stream
module nmea_sentence_gen
    import nmea_pkg::*;
#(
    parameter logic [15:0] TALKER      = 16'h4750,
    parameter logic [7:0]  STATUS_CHAR = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        start_ready,
    input  logic [31:0] utc_time,
    input  logic [31:0] latitude,
    input  logic        north,
    input  logic [31:0] longitude,
    input  logic        east,
    input  logic [31:0] ground_speed,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy
);

    state_t      state;
    logic [31:0] utc_f, lat_f, lon_f, spd_f;
    logic        north_f, east_f;
    logic        load_q;
    logic [1:0]  cvt_idx;
    logic [1:0]  bin_sel;
    logic        cvt_load;
    logic [31:0] cvt_bin;
    logic [4*BCD_DIGITS-1:0] cvt_bcd;
    logic        cvt_done;
    logic [4*UTC_DIGITS-1:0] utc_bcd;
    logic [4*LAT_DIGITS-1:0] lat_bcd;
    logic [4*LON_DIGITS-1:0] lon_bcd;
    logic [4*SPD_DIGITS-1:0] spd_bcd;
    logic [5:0]  idx;
    logic [5:0]  nidx;
    logic [7:0]  cs;
    logic [7:0]  next_byte;
    logic        unused_bcd;

    // The next conversion is loaded in the very cycle the previous one reports done
    assign bin_sel    = cvt_done ? (cvt_idx + 2'd1) : cvt_idx;
    assign cvt_load   = load_q || (cvt_done && cvt_idx != 2'd3);
    assign unused_bcd = ^cvt_bcd[4*BCD_DIGITS-1:4*UTC_DIGITS];

    always_comb begin
        cvt_bin = utc_f;
        case (bin_sel)
            2'd0:    cvt_bin = utc_f;
            2'd1:    cvt_bin = lat_f;
            2'd2:    cvt_bin = lon_f;
            default: cvt_bin = spd_f;
        endcase
    end

    nmea_bin2bcd u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .load (cvt_load),
        .bin  (cvt_bin),
        .bcd  (cvt_bcd),
        .done (cvt_done)
    );

    assign nidx = idx + 6'd1;

    always_comb begin
        next_byte = 8'h00;
        case (nidx)
            6'd0:  next_byte = ASCII_DOLLAR;
            6'd1:  next_byte = TALKER[15:8];
            6'd2:  next_byte = TALKER[7:0];
            6'd3:  next_byte = ASCII_R;
            6'd4:  next_byte = ASCII_M;
            6'd5:  next_byte = ASCII_C;
            6'd6, 6'd17, 6'd19, 6'd29, 6'd31, 6'd42, 6'd44,
            6'd51, 6'd52, 6'd53, 6'd54: next_byte = ASCII_COMMA;
            6'd13, 6'd24, 6'd37, 6'd48: next_byte = ASCII_DOT;
            6'd7:  next_byte = digit_ascii(utc_bcd[35:32]);
            6'd8:  next_byte = digit_ascii(utc_bcd[31:28]);
            6'd9:  next_byte = digit_ascii(utc_bcd[27:24]);
            6'd10: next_byte = digit_ascii(utc_bcd[23:20]);
            6'd11: next_byte = digit_ascii(utc_bcd[19:16]);
            6'd12: next_byte = digit_ascii(utc_bcd[15:12]);
            6'd14: next_byte = digit_ascii(utc_bcd[11:8]);
            6'd15: next_byte = digit_ascii(utc_bcd[7:4]);
            6'd16: next_byte = digit_ascii(utc_bcd[3:0]);
            6'd18: next_byte = STATUS_CHAR;
            6'd20: next_byte = digit_ascii(lat_bcd[31:28]);
            6'd21: next_byte = digit_ascii(lat_bcd[27:24]);
            6'd22: next_byte = digit_ascii(lat_bcd[23:20]);
            6'd23: next_byte = digit_ascii(lat_bcd[19:16]);
            6'd25: next_byte = digit_ascii(lat_bcd[15:12]);
            6'd26: next_byte = digit_ascii(lat_bcd[11:8]);
            6'd27: next_byte = digit_ascii(lat_bcd[7:4]);
            6'd28: next_byte = digit_ascii(lat_bcd[3:0]);
            6'd30: next_byte = north_f ? ASCII_N : ASCII_S;
            6'd32: next_byte = digit_ascii(lon_bcd[35:32]);
            6'd33: next_byte = digit_ascii(lon_bcd[31:28]);
            6'd34: next_byte = digit_ascii(lon_bcd[27:24]);
            6'd35: next_byte = digit_ascii(lon_bcd[23:20]);
            6'd36: next_byte = digit_ascii(lon_bcd[19:16]);
            6'd38: next_byte = digit_ascii(lon_bcd[15:12]);
            6'd39: next_byte = digit_ascii(lon_bcd[11:8]);
            6'd40: next_byte = digit_ascii(lon_bcd[7:4]);
            6'd41: next_byte = digit_ascii(lon_bcd[3:0]);
            6'd43: next_byte = east_f ? ASCII_E : ASCII_W;
            6'd45: next_byte = digit_ascii(spd_bcd[19:16]);
            6'd46: next_byte = digit_ascii(spd_bcd[15:12]);
            6'd47: next_byte = digit_ascii(spd_bcd[11:8]);
            6'd49: next_byte = digit_ascii(spd_bcd[7:4]);
            6'd50: next_byte = digit_ascii(spd_bcd[3:0]);
            6'd55: next_byte = ASCII_STAR;
            6'd56: next_byte = hex_ascii(cs[7:4]);
            6'd57: next_byte = hex_ascii(cs[3:0]);
            6'd58: next_byte = ASCII_CR;
            6'd59: next_byte = ASCII_LF;
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= '0;
            cs          <= '0;
            idx         <= '0;
            load_q      <= 1'b0;
            cvt_idx     <= '0;
            utc_f       <= '0;
            lat_f       <= '0;
            lon_f       <= '0;
            spd_f       <= '0;
            north_f     <= 1'b0;
            east_f      <= 1'b0;
            utc_bcd     <= '0;
            lat_bcd     <= '0;
            lon_bcd     <= '0;
            spd_bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && start_ready) begin
                        utc_f       <= saturate(utc_time, UTC_MAX);
                        lat_f       <= saturate(latitude, LAT_MAX);
                        lon_f       <= saturate(longitude, LON_MAX);
                        spd_f       <= saturate(ground_speed, SPD_MAX);
                        north_f     <= north;
                        east_f      <= east;
                        load_q      <= 1'b1;
                        cvt_idx     <= '0;
                        state       <= CONVERT;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CONVERT: begin
                    load_q <= 1'b0;
                    if (cvt_done) begin
                        case (cvt_idx)
                            2'd0:    utc_bcd <= cvt_bcd[4*UTC_DIGITS-1:0];
                            2'd1:    lat_bcd <= cvt_bcd[4*LAT_DIGITS-1:0];
                            2'd2:    lon_bcd <= cvt_bcd[4*LON_DIGITS-1:0];
                            default: spd_bcd <= cvt_bcd[4*SPD_DIGITS-1:0];
                        endcase
                        cvt_idx <= cvt_idx + 2'd1;
                        if (cvt_idx == 2'd3) begin
                            state    <= SEND;
                            m_tvalid <= 1'b1;
                            m_tdata  <= ASCII_DOLLAR;
                            m_tlast  <= 1'b0;
                            idx      <= '0;
                        end
                    end
                end
                SEND: begin
                    if (m_tvalid && m_tready) begin
                        if (idx >= CS_FIRST_IDX && idx <= CS_LAST_IDX) begin
                            cs <= cs ^ m_tdata;
                        end
                        if (idx == LAST_IDX) begin
                            state       <= IDLE;
                            m_tvalid    <= 1'b0;
                            m_tlast     <= 1'b0;
                            m_tdata     <= '0;
                            cs          <= '0;
                            start_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            idx     <= nidx;
                            m_tdata <= next_byte;
                            m_tlast <= (nidx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_sentence_gen.sv
// tb/tb_nmea_sentence_gen.sv - scoreboard bench for the RMC sentence generator
module tb_nmea_sentence_gen;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [31:0] utc_time = '0, latitude = '0, longitude = '0, ground_speed = '0;
    logic        north = 1'b0, east = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        busy;

    exp_t       sb_q[$];
    logic [7:0] rx_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         bp_mode = 1'b0;

    localparam string S1 = "$GPRMC,123519.000,A,4807.0380,N,01131.0000,E,022.40,,,,*";
    localparam string S3 = "$GPRMC,999999.999,A,9999.9999,S,99999.9999,W,999.99,,,,*";

    always #5 clk = ~clk;

    nmea_sentence_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_ready  (start_ready),
        .utc_time     (utc_time),
        .latitude     (latitude),
        .north        (north),
        .longitude    (longitude),
        .east         (east),
        .ground_speed (ground_speed),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_sentence(input string body);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 1; i <= body.len() - 2; i++) cs = cs ^ body[i];
        for (int i = 0; i < body.len(); i++) sb_q.push_back('{d: body[i], l: 1'b0});
        sb_q.push_back('{d: hexc(cs[7:4]), l: 1'b0});
        sb_q.push_back('{d: hexc(cs[3:0]), l: 1'b0});
        sb_q.push_back('{d: 8'h0D, l: 1'b0});
        sb_q.push_back('{d: 8'h0A, l: 1'b1});
    endtask

    task automatic run(input logic [31:0] u, input logic [31:0] la, input logic n,
                       input logic [31:0] lo, input logic e, input logic [31:0] sp,
                       input bit measure);
        int lat_cyc;
        @(posedge clk); #1;
        utc_time = u; latitude = la; north = n; longitude = lo; east = e; ground_speed = sp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        utc_time = '0; latitude = '0; north = ~n; longitude = '0; east = ~e; ground_speed = '0;
        if (measure) begin
            lat_cyc = 0;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk); #1;
                if (m_tvalid) begin
                    lat_cyc = k;
                    break;
                end
            end
            chk(lat_cyc == 133, "first_valid_latency", 32'(lat_cyc), 32'd133);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(!busy, "idle_timeout", 32'(busy), 32'd0);
        chk(sb_q.size() == 0, "drained", 32'(sb_q.size()), 32'd0);
    endtask

    function automatic int unsigned field(input logic [1023:0] pk, input int lo, input int hi);
        int unsigned v;
        logic [7:0]  b;
        v = 0;
        for (int p = lo; p <= hi; p++) begin
            b = pk[8*p +: 8];
            if (b != 8'h2E) v = v * 10 + int'(b - 8'h30);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        bit         stall;
        logic [7:0] hd;
        logic       hl;
        exp_t       e;
        stall = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (stall) begin
                chk(m_tvalid, "valid_held", 32'(m_tvalid), 32'd1);
                chk(m_tdata == hd, "data_held", 32'(m_tdata), 32'(hd));
                chk(m_tlast == hl, "last_held", 32'(m_tlast), 32'(hl));
            end
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    chk(1'b0, "unexpected_byte", 32'(m_tdata), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk(m_tdata == e.d, "byte", 32'(m_tdata), 32'(e.d));
                    chk(m_tlast == e.l, "tlast", 32'(m_tlast), 32'(e.l));
                end
                rx_q.push_back(m_tdata);
            end
            stall = m_tvalid && !m_tready && !rst;
            hd = m_tdata;
            hl = m_tlast;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            mark;
        logic [1023:0] pk;
        repeat (3) @(posedge clk);
        #1;
        chk(start_ready == 1'b1, "rst_start_ready", 32'(start_ready), 32'd1);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
        chk(m_tvalid == 1'b0, "rst_tvalid", 32'(m_tvalid), 32'd0);
        chk(m_tlast == 1'b0, "rst_tlast", 32'(m_tlast), 32'd0);
        chk(m_tdata == 8'h00, "rst_tdata", 32'(m_tdata), 32'd0);
        rst = 1'b0;

        // Basic sentence with continuous ready, then decode it back into fields
        mark = rx_q.size();
        push_sentence(S1);
        run(32'd123519000, 32'd48070380, 1'b1, 32'd11310000, 1'b1, 32'd2240, 1'b1);
        wait_idle();
        chk(rx_q.size() == mark + 60, "byte_count", 32'(rx_q.size() - mark), 32'd60);
        pk = '0;
        for (int i = 0; i < 60; i++) pk[8*i +: 8] = rx_q[mark + i];
        chk(field(pk, 7, 16) == 123519000, "rt_utc", field(pk, 7, 16), 32'd123519000);
        chk(field(pk, 20, 28) == 48070380, "rt_lat", field(pk, 20, 28), 32'd48070380);
        chk(pk[8*30 +: 8] == 8'h4E, "rt_north", 32'(pk[8*30 +: 8]), 32'h4E);
        chk(field(pk, 32, 41) == 11310000, "rt_lon", field(pk, 32, 41), 32'd11310000);
        chk(pk[8*43 +: 8] == 8'h45, "rt_east", 32'(pk[8*43 +: 8]), 32'h45);
        chk(field(pk, 45, 50) == 2240, "rt_speed", field(pk, 45, 50), 32'd2240);

        // Random backpressure
        bp_mode = 1'b1;
        mark = rx_q.size();
        push_sentence(S1);
        run(32'd123519000, 32'd48070380, 1'b1, 32'd11310000, 1'b1, 32'd2240, 1'b0);
        wait_idle();
        bp_mode = 1'b0;
        chk(rx_q.size() == mark + 60, "bp_byte_count", 32'(rx_q.size() - mark), 32'd60);

        // Saturation with south/west
        push_sentence(S3);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 32'd123456, 1'b0);
        wait_idle();

        // Reset in the middle of SEND, then a fresh sentence
        mark = rx_q.size();
        push_sentence(S1);
        run(32'd123519000, 32'd48070380, 1'b1, 32'd11310000, 1'b1, 32'd2240, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rx_q.size() >= mark + 20) break;
        end
        chk(rx_q.size() >= mark + 20, "reach_byte20", 32'(rx_q.size() - mark), 32'd20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        chk(m_tvalid == 1'b0, "midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk(start_ready == 1'b1, "midrst_start_ready", 32'(start_ready), 32'd1);
        chk(busy == 1'b0, "midrst_busy", 32'(busy), 32'd0);
        chk(m_tdata == 8'h00, "midrst_tdata", 32'(m_tdata), 32'd0);
        push_sentence(S1);
        run(32'd123519000, 32'd48070380, 1'b1, 32'd11310000, 1'b1, 32'd2240, 1'b0);
        wait_idle();

        // Start pulses during CONVERT and SEND must be ignored
        mark = rx_q.size();
        push_sentence(S1);
        run(32'd123519000, 32'd48070380, 1'b1, 32'd11310000, 1'b1, 32'd2240, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        utc_time = 32'd1; latitude = 32'd2; longitude = 32'd3; ground_speed = 32'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (m_tvalid) break;
        end
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (200) @(posedge clk);
        #1;
        chk(rx_q.size() == mark + 60, "single_sentence", 32'(rx_q.size() - mark), 32'd60);
        chk(busy == 1'b0, "stay_idle", 32'(busy), 32'd0);
        chk(start_ready == 1'b1, "end_start_ready", 32'(start_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
